// File: rtl/cam_yuv_splitter_if.sv
// Camera byte stream plus the three FWFT z/vz/lz output channels of the YUV splitter.
interface cam_yuv_splitter_if;
   logic [7:0] cam_data;
   logic       cam_valid;
   logic       cam_sof;
   logic       cam_eol;
   logic       cam_eof;
   logic [7:0] y_data_z;
   logic       y_data_vz;
   logic       y_data_lz;
   logic [7:0] u_data_z;
   logic       u_data_vz;
   logic       u_data_lz;
   logic [7:0] v_data_z;
   logic       v_data_vz;
   logic       v_data_lz;

   modport slave (
      input  cam_data, cam_valid, cam_sof, cam_eol, cam_eof,
      input  y_data_lz, u_data_lz, v_data_lz,
      output y_data_z, y_data_vz, u_data_z, u_data_vz, v_data_z, v_data_vz
   );

   modport master (
      output cam_data, cam_valid, cam_sof, cam_eol, cam_eof,
      output y_data_lz, u_data_lz, v_data_lz,
      input  y_data_z, y_data_vz, u_data_z, u_data_vz, v_data_z, v_data_vz
   );
endinterface

// File: rtl/cam_yuv_splitter.sv
// Splits a packed 4:2:2 camera byte stream into Y/U/V FWFT FIFO channels, optional 4:2:0 chroma drop.
// Define CAM_YUV_SPLIT_STATS_EN to add the frame_cnt / drop_cnt statistics outputs.
//
// state      | meaning
// ST_IDLE    | disabled, all camera bytes ignored
// ST_ARMED   | enabled, waiting for a byte with cam_sof
// ST_CAPTURE | steering bytes of the current frame into the FIFOs
module cam_yuv_splitter #(
   parameter int Y_DEPTH = 16,
   parameter int C_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            ctrl_in,
   cam_yuv_splitter_if.slave     bus,
   output logic                  status_out,
   output logic                  frame_done
`ifdef CAM_YUV_SPLIT_STATS_EN
   ,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           drop_cnt
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   logic       enable, flush, mode_420, order_uyvy;
   logic [1:0] state;
   logic [1:0] phase;
   logic       parity, uyvy_q, m420_q;
   logic       sof_take, take;
   logic [1:0] cur_phase;
   logic       cur_par, cur_uyvy, cur_420, is_y, keep_c;
   logic [2:0] push, pop, drop, lz, vz;
   logic [7:0] head [3];

   assign enable     = ctrl_in[0];
   assign flush      = ctrl_in[1];
   assign mode_420   = ctrl_in[2];
   assign order_uyvy = ctrl_in[3];

   // A byte carrying sof restarts position and latches the frame format, even mid-capture.
   always_comb begin
      sof_take  = ~flush & bus.cam_valid & bus.cam_sof &
                  (((state == ST_ARMED) & enable) | (state == ST_CAPTURE));
      take      = sof_take | (~flush & bus.cam_valid & (state == ST_CAPTURE));
      cur_phase = sof_take ? 2'd0 : phase;
      cur_par   = sof_take ? 1'b0 : parity;
      cur_uyvy  = sof_take ? order_uyvy : uyvy_q;
      cur_420   = sof_take ? mode_420 : m420_q;
      is_y      = (cur_phase[0] == cur_uyvy);
      keep_c    = ~(cur_420 & cur_par);
      push[0]   = take & is_y;
      push[1]   = take & ~is_y & ~cur_phase[1] & keep_c;
      push[2]   = take & ~is_y &  cur_phase[1] & keep_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         phase      <= 2'd0;
         parity     <= 1'b0;
         uyvy_q     <= 1'b0;
         m420_q     <= 1'b0;
         frame_done <= 1'b0;
      end else if (flush) begin
         state      <= ST_IDLE;
         phase      <= 2'd0;
         parity     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= take & bus.cam_eof;
         if (take & bus.cam_eof)
            state <= enable ? ST_ARMED : ST_IDLE;
         else if (sof_take)
            state <= ST_CAPTURE;
         else if ((state == ST_IDLE) & enable)
            state <= ST_ARMED;
         else if ((state == ST_ARMED) & ~enable)
            state <= ST_IDLE;
         if (take) begin
            if (bus.cam_eol) begin
               phase  <= 2'd0;
               parity <= ~cur_par;
            end else begin
               phase  <= cur_phase + 2'd1;
               parity <= cur_par;
            end
         end
         if (sof_take) begin
            uyvy_q <= order_uyvy;
            m420_q <= mode_420;
         end
      end
   end

   assign lz = {bus.v_data_lz, bus.u_data_lz, bus.y_data_lz};

   for (genvar g = 0; g < 3; g++) begin : g_fifo
      localparam int DEPTH = (g == 0) ? Y_DEPTH : C_DEPTH;
      localparam int AW    = $clog2(DEPTH);
      localparam logic [AW:0] PTR_ONE = 1;

      logic [7:0]  mem [DEPTH];
      logic [AW:0] wr_ptr, rd_ptr;
      logic        empty, full, wr_en;

      // Extra pointer MSB separates full from empty when the index bits match.
      assign empty   = (wr_ptr == rd_ptr);
      assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
      assign vz[g]   = ~empty;
      assign pop[g]  = ~empty & lz[g];
      assign drop[g] = push[g] & full & ~pop[g];
      assign wr_en   = push[g] & ~drop[g];
      assign head[g] = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en)
               wr_ptr <= wr_ptr + PTR_ONE;
            if (pop[g])
               rd_ptr <= rd_ptr + PTR_ONE;
         end
      end

      always_ff @(posedge clk) begin
         if (wr_en)
            mem[wr_ptr[AW-1:0]] <= bus.cam_data;
      end
   end

   assign bus.y_data_z  = head[0];
   assign bus.u_data_z  = head[1];
   assign bus.v_data_z  = head[2];
   assign bus.y_data_vz = vz[0];
   assign bus.u_data_vz = vz[1];
   assign bus.v_data_vz = vz[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         status_out <= 1'b0;
      else if (flush)
         status_out <= 1'b0;
      else if (|drop)
         status_out <= 1'b1;
   end

`ifdef CAM_YUV_SPLIT_STATS_EN
   // At most one byte arrives per cycle, so at most one drop bit is ever set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 16'd0;
         drop_cnt  <= 16'd0;
      end else if (flush) begin
         frame_cnt <= 16'd0;
         drop_cnt  <= 16'd0;
      end else begin
         if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
         if ((|drop) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cam_yuv_splitter.sv
// Scoreboard bench for cam_yuv_splitter: expected Y/U/V bytes queued at drive time, compared on pop.
module tb_cam_yuv_splitter;
   localparam int Y_DEPTH = 16;
   localparam int C_DEPTH = 8;
   localparam int CH_Y    = 0;
   localparam int CH_U    = 1;
   localparam int CH_V    = 2;
   localparam int CH_NONE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] ctrl;
   logic       status_out, frame_done;
`ifdef CAM_YUV_SPLIT_STATS_EN
   logic [15:0] frame_cnt, drop_cnt;
`endif

   cam_yuv_splitter_if bus ();

   cam_yuv_splitter #(.Y_DEPTH(Y_DEPTH), .C_DEPTH(C_DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctrl_in    (ctrl),
      .bus        (bus),
      .status_out (status_out),
      .frame_done (frame_done)
`ifdef CAM_YUV_SPLIT_STATS_EN
      ,
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [7:0] y_q[$];
   logic [7:0] u_q[$];
   logic [7:0] v_q[$];
   bit exp_fd = 1'b0;
   bit exp_status = 1'b0;
   int exp_drops = 0;
   int exp_frames = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int ch_of(input int ph, input bit uyvy, input bit m420, input bit par);
      if ((ph % 2) == int'(uyvy)) return CH_Y;
      if (m420 && par) return CH_NONE;
      return (ph < 2) ? CH_U : CH_V;
   endfunction

   task automatic clear_model();
      y_q.delete();
      u_q.delete();
      v_q.delete();
      exp_fd = 1'b0;
      exp_status = 1'b0;
      exp_drops = 0;
      exp_frames = 0;
   endtask

   task automatic monitor();
      check_val("frame_done", 32'(frame_done), 32'(exp_fd));
      check_val("status", 32'(status_out), 32'(exp_status));
      check_val("y_vz", 32'(bus.y_data_vz), 32'(y_q.size() > 0));
      check_val("u_vz", 32'(bus.u_data_vz), 32'(u_q.size() > 0));
      check_val("v_vz", 32'(bus.v_data_vz), 32'(v_q.size() > 0));
      if (bus.y_data_vz && bus.y_data_lz && y_q.size() > 0)
         check_val("y_data", 32'(bus.y_data_z), 32'(y_q.pop_front()));
      if (bus.u_data_vz && bus.u_data_lz && u_q.size() > 0)
         check_val("u_data", 32'(bus.u_data_z), 32'(u_q.pop_front()));
      if (bus.v_data_vz && bus.v_data_lz && v_q.size() > 0)
         check_val("v_data", 32'(bus.v_data_z), 32'(v_q.pop_front()));
   endtask

   task automatic model_push(input int ch, input logic [7:0] d);
      int sz;
      int depth;
      depth = (ch == CH_Y) ? Y_DEPTH : C_DEPTH;
      sz = (ch == CH_Y) ? y_q.size() : (ch == CH_U) ? u_q.size() : v_q.size();
      if (sz < depth) begin
         case (ch)
            CH_Y:    y_q.push_back(d);
            CH_U:    u_q.push_back(d);
            default: v_q.push_back(d);
         endcase
      end else begin
         exp_status = 1'b1;
         if (exp_drops < 65535) exp_drops++;
      end
   endtask

   task automatic drive(input logic [7:0] d, input bit v, input bit sof, input bit eol,
                        input bit eof, input bit cap, input int ch);
      bus.cam_data  = d;
      bus.cam_valid = v;
      bus.cam_sof   = sof;
      bus.cam_eol   = eol;
      bus.cam_eof   = eof;
      @(negedge clk);
      monitor();
      if (ctrl[1]) begin
         clear_model();
      end else begin
         exp_fd = v & cap & eof;
         if (exp_fd) exp_frames++;
         if (v && ch != CH_NONE) model_push(ch, d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CH_NONE);
   endtask

   task automatic send_frame(input int lines, input int bpl, input logic [7:0] base,
                             input bit uyvy, input bit m420, input bit cap, input int dis_at);
      int n;
      bit last;
      logic [7:0] d;
      ctrl[3] = uyvy;
      ctrl[2] = m420;
      n = 0;
      for (int l = 0; l < lines; l++) begin
         for (int i = 0; i < bpl; i++) begin
            if (n == dis_at) ctrl[0] = 1'b0;
            last = (i == bpl - 1);
            d = base + 8'(n);
            drive(d, 1'b1, n == 0, last, last && (l == lines - 1), cap,
                  cap ? ch_of(i % 4, uyvy, m420, l[0]) : CH_NONE);
            n++;
         end
      end
   endtask

   task automatic send_partial(input int nbytes, input logic [7:0] base);
      logic [7:0] d;
      ctrl[3:2] = 2'b00;
      for (int i = 0; i < nbytes; i++) begin
         d = base + 8'(i);
         drive(d, 1'b1, i == 0, 1'b0, 1'b0, 1'b1, ch_of(i % 4, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic check_quiet(input string tag);
      check_val({tag, "_y_vz"}, 32'(bus.y_data_vz), 32'd0);
      check_val({tag, "_u_vz"}, 32'(bus.u_data_vz), 32'd0);
      check_val({tag, "_v_vz"}, 32'(bus.v_data_vz), 32'd0);
      check_val({tag, "_y_z"}, 32'(bus.y_data_z), 32'd0);
      check_val({tag, "_u_z"}, 32'(bus.u_data_z), 32'd0);
      check_val({tag, "_v_z"}, 32'(bus.v_data_z), 32'd0);
      check_val({tag, "_status"}, 32'(status_out), 32'd0);
      check_val({tag, "_fd"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      ctrl = 4'b0000;
      bus.cam_data = 8'h00;
      bus.cam_valid = 1'b0;
      bus.cam_sof = 1'b0;
      bus.cam_eol = 1'b0;
      bus.cam_eof = 1'b0;
      bus.y_data_lz = 1'b1;
      bus.u_data_lz = 1'b1;
      bus.v_data_lz = 1'b1;
      #2;
      check_quiet("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // basic YUYV, 2 lines x 8 bytes
      ctrl = 4'b0001;
      idle(1);
      send_frame(2, 8, 8'h00, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // UYVY with 4:2:0 chroma drop
      send_frame(2, 4, 8'hA0, 1'b1, 1'b1, 1'b1, -1);
      idle(4);

      // Y backpressure and overflow
      bus.y_data_lz = 1'b0;
      send_frame(5, 8, 8'h10, 1'b0, 1'b0, 1'b1, -1);
      idle(2);
      bus.y_data_lz = 1'b1;
      idle(20);
`ifdef CAM_YUV_SPLIT_STATS_EN
      check_val("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

      // flush, then fill Y exactly full and push into it while popping
      ctrl = 4'b0011;
      idle(1);
      ctrl = 4'b0001;
      idle(1);
      bus.y_data_lz = 1'b0;
      send_frame(1, 32, 8'h40, 1'b0, 1'b0, 1'b1, -1);
      bus.y_data_lz = 1'b1;
      send_frame(1, 8, 8'h80, 1'b0, 1'b0, 1'b1, -1);
      idle(20);

      // bytes before sof are discarded; enable dropped mid-frame
      for (int i = 0; i < 5; i++)
         drive(8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CH_NONE);
      send_frame(2, 8, 8'h20, 1'b0, 1'b0, 1'b1, 5);
      idle(2);
      send_frame(1, 8, 8'h30, 1'b0, 1'b0, 1'b0, -1);
      idle(2);

      // sof while capturing restarts the frame
      ctrl = 4'b0001;
      idle(1);
      send_partial(3, 8'h60);
      send_frame(1, 8, 8'h68, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // flush mid-frame after an overflow
      bus.y_data_lz = 1'b0;
      send_partial(40, 8'h00);
      ctrl = 4'b0011;
      idle(1);
      ctrl = 4'b0001;
      bus.y_data_lz = 1'b1;
      idle(1);
      send_frame(1, 8, 8'h90, 1'b0, 1'b0, 1'b1, -1);
      idle(4);

      // asynchronous reset mid-frame
      bus.y_data_lz = 1'b0;
      send_partial(40, 8'h00);
      rst_n = 1'b0;
      #2;
      check_quiet("midrst");
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.y_data_lz = 1'b1;
      idle(1);
      send_frame(1, 8, 8'hC0, 1'b0, 1'b0, 1'b1, -1);
      idle(4);
`ifdef CAM_YUV_SPLIT_STATS_EN
      check_val("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      check_val("drop_cnt_end", 32'(drop_cnt), 32'(exp_drops));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
